// File: rtl/stack_calc_pkg.sv
// Shared definitions for the stack calculator.
//   - DwDefault: default operand / LIFO data width
//   - op_e:      command opcodes presented on cmd_op_i
//   - state_e:   controller FSM state encoding
package stack_calc_pkg;

  parameter int unsigned DwDefault = 16;

  typedef enum logic [2:0] {
    OpPush = 3'b000,
    OpPop  = 3'b001,
    OpAdd  = 3'b010,
    OpSub  = 3'b011,
    OpAnd  = 3'b100,
    OpOr   = 3'b101,
    OpXor  = 3'b110,
    OpRsvd = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPopA  = 3'd1,
    StPopB  = 3'd2,
    StCalc  = 3'd3,
    StPushR = 3'd4,
    StDone  = 3'd5,
    StErr   = 3'd6
  } state_e;

  // True for the two-operand opcodes that consume two entries and push one.
  function automatic logic is_binop(op_e op);
    return (op == OpAdd) || (op == OpSub) || (op == OpAnd) || (op == OpOr) || (op == OpXor);
  endfunction

endpackage

// File: rtl/stack_alu.sv
// Combinational datapath computing B op A for the stack calculator.
//   op_i : opcode (only ADD/SUB/AND/OR/XOR produce a value, others give 0)
//   a_i  : first popped entry (top of stack)
//   b_i  : second popped entry (deeper entry)
//   r_o  : result, modulo 2^DW
module stack_alu
  import stack_calc_pkg::*;
#(
  parameter int unsigned DW = DwDefault
) (
  input  logic [2:0]    op_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] r_o
);

  always_comb begin
    r_o = '0;
    case (op_e'(op_i))
      OpAdd:   r_o = b_i + a_i;  // carry dropped by the DW-bit result
      OpSub:   r_o = b_i - a_i;  // deeper minus top, borrow dropped
      OpAnd:   r_o = b_i & a_i;
      OpOr:    r_o = b_i | a_i;
      OpXor:   r_o = b_i ^ a_i;
      default: r_o = '0;
    endcase
  end

endmodule

// File: rtl/stack_calc.sv
// Stack calculator controller driving an external LIFO.
// Accepts one command at a time (PUSH, POP, ADD, SUB, AND, OR, XOR), pops operands
// from the LIFO, evaluates B op A and pushes the result back.
//   clk, rst          : clock, synchronous active-low reset
//   cmd_valid_i/op/imm: command offer, accepted while cmd_ready_o is high
//   done_o, err_o     : one-cycle completion pulse, err_o flags a rejected command
//   result_o          : last pushed/popped/computed value
//   lifo_*            : request/data/status interface to the LIFO
module stack_calc
  import stack_calc_pkg::*;
#(
  parameter int unsigned DW = DwDefault,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid_i,
  input  logic [2:0]    cmd_op_i,
  input  logic [DW-1:0] cmd_imm_i,
  output logic          cmd_ready_o,
  output logic          done_o,
  output logic          err_o,
  output logic [DW-1:0] result_o,
  output logic          lifo_wr_req_o,
  output logic [DW-1:0] lifo_wr_data_o,
  output logic          lifo_rd_req_o,
  input  logic [DW-1:0] lifo_rd_data_i,
  input  logic          lifo_empty_i,
  input  logic          lifo_full_i,
  input  logic [AW-1:0] lifo_amount_i
);

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [DW-1:0] imm_q, imm_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] r_q, r_d;
  logic [DW-1:0] result_q, result_d;
  logic [DW-1:0] alu_r;

  stack_alu #(
    .DW (DW)
  ) u_alu (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .r_o  (alu_r)
  );

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    imm_d          = imm_q;
    a_d            = a_q;
    b_d            = b_q;
    r_d            = r_q;
    result_d       = result_q;
    cmd_ready_o    = 1'b0;
    done_o         = 1'b0;
    err_o          = 1'b0;
    lifo_wr_req_o  = 1'b0;
    lifo_wr_data_o = '0;
    lifo_rd_req_o  = 1'b0;

    case (state_q)
      StIdle: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          op_d  = op_e'(cmd_op_i);
          imm_d = cmd_imm_i;
          // Reject up front so a failing command never touches the LIFO.
          case (op_e'(cmd_op_i))
            OpPush:  state_d = lifo_full_i ? StErr : StPushR;
            OpPop:   state_d = lifo_empty_i ? StErr : StPopA;
            OpRsvd:  state_d = StErr;
            default: begin
              if (is_binop(op_e'(cmd_op_i)) && (lifo_amount_i >= AW'(2))) begin
                state_d = StPopA;
              end else begin
                state_d = StErr;
              end
            end
          endcase
        end
      end
      StPopA: begin
        lifo_rd_req_o = 1'b1;
        a_d           = lifo_rd_data_i;
        if (op_q == OpPop) begin
          result_d = lifo_rd_data_i;
          state_d  = StDone;
        end else begin
          state_d = StPopB;
        end
      end
      StPopB: begin
        lifo_rd_req_o = 1'b1;
        b_d           = lifo_rd_data_i;
        state_d       = StCalc;
      end
      StCalc: begin
        r_d     = alu_r;
        state_d = StPushR;
      end
      StPushR: begin
        lifo_wr_req_o  = 1'b1;
        lifo_wr_data_o = (op_q == OpPush) ? imm_q : r_q;
        result_d       = lifo_wr_data_o;
        state_d        = StDone;
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      StErr: begin
        done_o  = 1'b1;
        err_o   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      op_q     <= OpPush;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      imm_q    <= imm_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      result_q <= result_d;
    end
  end

  assign result_o = result_q;

endmodule

// File: tb/tb_stack_calc.sv
// Self-checking bench for stack_calc with a behavioural LIFO and a queue-based
// reference model of the calculator.
module tb_stack_calc;

  localparam int Depth = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic [2:0]  cmd_op_i = 3'd0;
  logic [15:0] cmd_imm_i = 16'd0;
  logic        cmd_ready_o, done_o, err_o;
  logic [15:0] result_o;
  logic        lifo_wr_req_o, lifo_rd_req_o;
  logic [15:0] lifo_wr_data_o, lifo_rd_data_i;
  logic        lifo_empty_i, lifo_full_i;
  logic [3:0]  lifo_amount_i;

  always #5 clk = ~clk;

  stack_calc #(
    .DW (16),
    .AW (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_op_i       (cmd_op_i),
    .cmd_imm_i      (cmd_imm_i),
    .cmd_ready_o    (cmd_ready_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .result_o       (result_o),
    .lifo_wr_req_o  (lifo_wr_req_o),
    .lifo_wr_data_o (lifo_wr_data_o),
    .lifo_rd_req_o  (lifo_rd_req_o),
    .lifo_rd_data_i (lifo_rd_data_i),
    .lifo_empty_i   (lifo_empty_i),
    .lifo_full_i    (lifo_full_i),
    .lifo_amount_i  (lifo_amount_i)
  );

  // Behavioural LIFO: top entry visible combinationally, shares the reset.
  logic [15:0] mem [Depth];
  logic [3:0]  cnt = 4'd0;

  always_comb begin
    lifo_rd_data_i = (cnt != 4'd0) ? mem[cnt - 4'd1] : 16'd0;
    lifo_empty_i   = (cnt == 4'd0);
    lifo_full_i    = (cnt == 4'(Depth));
    lifo_amount_i  = cnt;
  end

  always @(posedge clk) begin
    if (!rst) begin
      cnt <= 4'd0;
    end else if (lifo_wr_req_o && cnt < 4'(Depth)) begin
      mem[cnt[2:0]] <= lifo_wr_data_o;
      cnt           <= cnt + 4'd1;
    end else if (lifo_rd_req_o && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: stack contents (top at the back) and last result.
  logic [15:0] mq [$];
  logic [15:0] e_res = 16'd0;
  logic        e_err;
  int          e_lat, e_rd, e_wr;

  // Observations from the last driven command.
  logic        o_err;
  logic [15:0] o_res;
  int          o_lat, o_rd, o_wr;
  logic        o_bad;  // both requests together, or write data leaking outside a write

  task automatic model_exec(input logic [2:0] op, input logic [15:0] imm);
    logic [15:0] a, b, r;
    e_err = 1'b1; e_lat = 1; e_rd = 0; e_wr = 0;
    case (op)
      3'd0: if (mq.size() < Depth) begin
        mq.push_back(imm); e_res = imm; e_err = 1'b0; e_lat = 2; e_wr = 1;
      end
      3'd1: if (mq.size() > 0) begin
        e_res = mq.pop_back(); e_err = 1'b0; e_lat = 2; e_rd = 1;
      end
      3'd2, 3'd3, 3'd4, 3'd5, 3'd6: if (mq.size() >= 2) begin
        a = mq.pop_back();
        b = mq.pop_back();
        case (op)
          3'd2:    r = 16'((32'(b) + 32'(a)) % 32'h10000);
          3'd3:    r = 16'((32'h10000 + 32'(b) - 32'(a)) % 32'h10000);
          3'd4:    r = b & a;
          3'd5:    r = b | a;
          default: r = b ^ a;
        endcase
        mq.push_back(r); e_res = r; e_err = 1'b0; e_lat = 5; e_rd = 2; e_wr = 1;
      end
      default: ;
    endcase
  endtask

  // Called on a negedge; returns on the negedge where done_o is seen (or the bound expires).
  task automatic drive(input logic [2:0] op, input logic [15:0] imm, input logic junk);
    int n;
    cmd_valid_i = 1'b1; cmd_op_i = op; cmd_imm_i = imm;
    n = 0;
    while (!cmd_ready_o && n < 10) begin
      @(negedge clk); n++;
    end
    @(posedge clk);
    #1;
    // Optionally keep offering a PUSH while busy; it must be ignored.
    cmd_valid_i = junk; cmd_op_i = 3'd0; cmd_imm_i = 16'($urandom);
    o_lat = 0; o_rd = 0; o_wr = 0; o_bad = 1'b0; o_err = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (lifo_rd_req_o) o_rd++;
      if (lifo_wr_req_o) o_wr++;
      if ((lifo_rd_req_o && lifo_wr_req_o) || (!lifo_wr_req_o && lifo_wr_data_o != 16'd0))
        o_bad = 1'b1;
      if (done_o) begin
        o_lat = k; o_err = err_o;
        break;
      end
    end
    cmd_valid_i = 1'b0;
    #1;
    o_res = result_o;
  endtask

  task automatic do_reset();
    @(negedge clk);
    cmd_valid_i = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mq.delete();
    e_res = 16'd0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cmd_ready_o, done_o, err_o, lifo_wr_req_o, lifo_rd_req_o} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 10000",
               {cmd_ready_o, done_o, err_o, lifo_wr_req_o, lifo_rd_req_o});
    end
    n_checks++;
    if (result_o !== 16'd0 || lifo_wr_data_o !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_data: result %h wr_data %h want 0 0", result_o, lifo_wr_data_o);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sub();
    do_reset();
    drive(3'd0, 16'd5, 1'b0); model_exec(3'd0, 16'd5);
    drive(3'd0, 16'd3, 1'b0); model_exec(3'd0, 16'd3);
    drive(3'd3, 16'd0, 1'b0); model_exec(3'd3, 16'd0);
    n_checks++;
    if (o_err !== 1'b0 || o_lat != 5) begin
      n_fail++; $display("FAIL sub_timing: err %b lat %0d want 0 5", o_err, o_lat);
    end
    n_checks++;
    if (o_res !== 16'd2 || lifo_amount_i !== 4'd1 || mem[0] !== 16'd2) begin
      n_fail++;
      $display("FAIL sub_value: result %h amount %0d top %h want 2 1 2",
               o_res, lifo_amount_i, mem[0]);
    end
    n_checks++;
    if (o_rd != 2 || o_wr != 1 || o_bad) begin
      n_fail++; $display("FAIL sub_reqs: rd %0d wr %0d bad %b want 2 1 0", o_rd, o_wr, o_bad);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(3'd0, 16'h0001, 1'b0); model_exec(3'd0, 16'h0001);
    drive(3'd0, 16'hFFFF, 1'b0); model_exec(3'd0, 16'hFFFF);
    drive(3'd2, 16'd0, 1'b0); model_exec(3'd2, 16'd0);
    n_checks++;
    if (o_err !== 1'b0 || o_res !== 16'h0000 || lifo_amount_i !== 4'd1) begin
      n_fail++;
      $display("FAIL add_wrap: err %b result %h amount %0d want 0 0000 1",
               o_err, o_res, lifo_amount_i);
    end
  endtask

  task automatic test_pop_empty();
    do_reset();
    drive(3'd0, 16'h1234, 1'b0); model_exec(3'd0, 16'h1234);
    drive(3'd1, 16'd0, 1'b0); model_exec(3'd1, 16'd0);
    n_checks++;
    if (o_err !== 1'b0 || o_lat != 2 || o_res !== 16'h1234 || o_rd != 1) begin
      n_fail++;
      $display("FAIL pop: err %b lat %0d result %h rd %0d want 0 2 1234 1",
               o_err, o_lat, o_res, o_rd);
    end
    drive(3'd1, 16'd0, 1'b0); model_exec(3'd1, 16'd0);
    n_checks++;
    if (o_err !== 1'b1 || o_lat != 1 || o_rd != 0 || o_res !== 16'h1234) begin
      n_fail++;
      $display("FAIL pop_empty: err %b lat %0d rd %0d result %h want 1 1 0 1234",
               o_err, o_lat, o_rd, o_res);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < Depth; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      drive(3'd0, v, 1'b0); model_exec(3'd0, v);
    end
    drive(3'd0, 16'd7, 1'b0); model_exec(3'd0, 16'd7);
    n_checks++;
    if (o_err !== 1'b1 || o_wr != 0 || lifo_amount_i !== 4'd8 || o_lat != 1) begin
      n_fail++;
      $display("FAIL push_full: err %b wr %0d amount %0d lat %0d want 1 0 8 1",
               o_err, o_wr, lifo_amount_i, o_lat);
    end
    for (int i = 0; i < Depth; i++) begin
      n_checks++;
      if (mem[i] !== mq[i]) begin
        n_fail++; $display("FAIL full_content[%0d]: got %h want %h", i, mem[i], mq[i]);
      end
    end
  endtask

  task automatic test_binop_err();
    do_reset();
    drive(3'd0, 16'hBEEF, 1'b0); model_exec(3'd0, 16'hBEEF);
    drive(3'd2, 16'd0, 1'b0); model_exec(3'd2, 16'd0);
    n_checks++;
    if (o_err !== 1'b1 || o_lat != 1 || o_rd != 0 || o_res !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL add_short: err %b lat %0d rd %0d result %h want 1 1 0 beef",
               o_err, o_lat, o_rd, o_res);
    end
    drive(3'd7, 16'h5555, 1'b0); model_exec(3'd7, 16'h5555);
    n_checks++;
    if (o_err !== 1'b1 || o_lat != 1 || o_wr != 0 || o_rd != 0) begin
      n_fail++;
      $display("FAIL rsvd_op: err %b lat %0d wr %0d rd %0d want 1 1 0 0",
               o_err, o_lat, o_wr, o_rd);
    end
    n_checks++;
    if (lifo_amount_i !== 4'd1 || mem[0] !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL err_intact: amount %0d top %h want 1 beef", lifo_amount_i, mem[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    do_reset();
    drive(3'd0, 16'h00F0, 1'b0); model_exec(3'd0, 16'h00F0);
    drive(3'd0, 16'h0F0F, 1'b0); model_exec(3'd0, 16'h0F0F);
    @(negedge clk);
    cmd_valid_i = 1'b1; cmd_op_i = 3'd6;
    @(posedge clk);
    #1 cmd_valid_i = 1'b0;
    @(negedge clk);  // POP_A
    @(negedge clk);  // POP_B
    n_checks++;
    if (lifo_rd_req_o !== 1'b1) begin
      n_fail++; $display("FAIL mid_popb: rd_req %b want 1", lifo_rd_req_o);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mq.delete(); e_res = 16'd0;
    n_checks++;
    if ({cmd_ready_o, done_o, err_o, lifo_wr_req_o, lifo_rd_req_o} !== 5'b10000
        || result_o !== 16'd0 || lifo_wr_data_o !== 16'd0 || lifo_amount_i !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_reset: ctrl %b result %h wr_data %h amount %0d want 10000 0 0 0",
               {cmd_ready_o, done_o, err_o, lifo_wr_req_o, lifo_rd_req_o},
               result_o, lifo_wr_data_o, lifo_amount_i);
    end
    saw_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done_o) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) begin
      n_fail++; $display("FAIL mid_nodone: done seen %b want 0", saw_done);
    end
  endtask

  // Random commands issued back to back, with a PUSH offered while busy.
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 120; i++) begin
      int sel;
      logic [2:0] op;
      logic [15:0] imm;
      sel = int'($urandom_range(0, 19));
      if (sel < 7)       op = 3'd0;
      else if (sel < 9)  op = 3'd1;
      else if (sel < 19) op = 3'($urandom_range(2, 6));
      else               op = 3'd7;
      imm = 16'($urandom);
      drive(op, imm, 1'b1);
      model_exec(op, imm);
      n_checks++;
      if (o_err !== e_err || o_lat != e_lat) begin
        n_fail++;
        $display("FAIL rnd_status[%0d] op %0d: err %b lat %0d want %b %0d",
                 i, op, o_err, o_lat, e_err, e_lat);
      end
      n_checks++;
      if (o_res !== e_res) begin
        n_fail++; $display("FAIL rnd_result[%0d] op %0d: got %h want %h", i, op, o_res, e_res);
      end
      n_checks++;
      if (o_rd != e_rd || o_wr != e_wr || o_bad || lifo_amount_i != 4'(mq.size())) begin
        n_fail++;
        $display("FAIL rnd_lifo[%0d] op %0d: rd %0d wr %0d bad %b amount %0d want %0d %0d 0 %0d",
                 i, op, o_rd, o_wr, o_bad, lifo_amount_i, e_rd, e_wr, mq.size());
      end
    end
    for (int i = 0; i < mq.size(); i++) begin
      n_checks++;
      if (mem[i] !== mq[i]) begin
        n_fail++; $display("FAIL rnd_content[%0d]: got %h want %h", i, mem[i], mq[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sub();
    test_wrap();
    test_pop_empty();
    test_full();
    test_binop_err();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
